fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end; drives the shared read address bus and consumes the words the memory slaves (RAM, ROM) place on the data bus.
- Issues sequential fetch addresses on read_clk and captures the returned words one read_clk later.
- Holds captured words in a small prefetch FIFO and hands them to the decoder over a valid/ready handshake.
- Handles jumps by flushing the FIFO and any in-flight word.

Parameters:
- WORD_SIZE, 16, width of address and data buses (from the bus header).
- DEPTH, 4, prefetch FIFO entries (power of two, at least 2).
- RESET_VECTOR, 16'h0000, first fetch address after reset.
- FETCH_LO, `RAM_START, inclusive lower bound of the legal fetch range (fault feature only).
- FETCH_HI, `RAM_END, exclusive upper bound of the legal fetch range (fault feature only).

Ports:
- reset  input  1  asynchronous, active-high.
- read_clk  input  1  clock; all state updates on the posedge.
- read_bus  output  WORD_SIZE  fetch address; valid while read_bus_en=1, otherwise 0.
- read_bus_en  output  1  unit owns read_bus this cycle (arbiter/tristate enable).
- bus_grant  input  1  arbiter allows an issue this cycle.
- data_bus  input  WORD_SIZE  word returned by the addressed slave.
- jump_en  input  1  redirect request, sampled on posedge.
- jump_addr  input  WORD_SIZE  redirect target.
- instr  output  WORD_SIZE  FIFO head word.
- instr_addr  output  WORD_SIZE  address the head word was fetched from.
- instr_valid  output  1  head entry present.
- instr_ready  input  1  decoder accepts the head; pop occurs when valid and ready.
- fetch_fault  output  1  present only with FETCH_FAULT_EN.

Behaviour:
- Reset is decided as: reset reset, asynchronous, active-high; clock read_clk.
- Reset values:
  - fetch_pc=RESET_VECTOR, issued_addr=0.
  - FIFO empty (count=0, rd/wr pointers 0), inflight=0.
  - read_bus_en=0, read_bus=0.
  - instr_valid=0, instr=0, instr_addr=0, fetch_fault=0.
- Reset mid-operation discards everything, including any in-flight word.
- Registered outputs: read_bus and read_bus_en. Combinational from the FIFO head: instr, instr_addr, instr_valid.
- pop = instr_valid & instr_ready.
- space_ok = (count + inflight - pop) < DEPTH.
- issue = bus_grant & space_ok & !jump_en (& !fault with the feature).
- Per posedge, in priority order:
  1. jump_en:
     - FIFO cleared (count=0, pointers reset), inflight=0.
     - Returned word on data_bus discarded.
     - fetch_pc=jump_addr, read_bus_en=0 for the next cycle.
     - A pop in the same cycle is void: jump wins.
  2. Capture when inflight=1: write {data_bus, issued_addr} at wr_ptr, count+1.
  3. Pop: rd_ptr+1, count-1. Simultaneous capture and pop leaves count unchanged.
  4. Issue:
     - read_bus=fetch_pc, read_bus_en=1, issued_addr=fetch_pc, inflight=1.
     - fetch_pc+1, wrapping 16'hFFFF to 16'h0000.
  5. No issue: read_bus_en=0, read_bus=0, inflight=0.
- Latency:
  - Address issued on edge N.
  - Slave drives data_bus during cycle N.
  - Word captured on edge N+1; instr_valid visible after edge N+1.
  - Sustained throughput is 1 word per cycle when bus_grant=1 and the decoder stays ready.
- Full FIFO: no issue until a pop frees a slot. An in-flight word always has a reserved slot, so overflow is impossible.
- Empty FIFO: instr_valid=0; instr and instr_addr hold the stale head, which is don't-care.
- bus_grant low: the in-flight capture still completes on the next edge; no new issue.
- Pointers wrap modulo DEPTH. count is clog2(DEPTH)+1 bits.

Optional Feature:
- Macro: FETCH_FAULT_EN.
- Defined:
  - An issue attempt with fetch_pc outside [FETCH_LO, FETCH_HI) sets sticky fetch_fault=1 and suppresses that issue and all later issues.
  - Already-buffered words still drain normally.
  - Only jump_en (to an in-range target) or reset clears the fault.
  - A jump to an out-range target faults on the next issue attempt.
- Undefined:
  - No range check; fetch_fault port absent.
  - Any address is fetched; wrap continues through the whole address space.

Decomposition:
- Shared header (bus/addresses headers): WORD_SIZE, `WORD, `RAM_START/`RAM_END, and a new FETCH_DEPTH default.
- One natural sub-module: fetch_fifo, a DEPTH x (2*WORD_SIZE) synchronous FIFO with async reset.
  - Interface: push, pop, flush, count, head.
  - fetch_unit keeps the PC, issue/inflight logic and the fault logic.

Test Plan:
- Reset, RESET_VECTOR=16'h0100, grant=1, ready=1, memory returns addr^16'hA5A5 → read_bus 0100,0101,0102… on consecutive edges; instr=16'hA4A5 with instr_addr=0100 valid after the 2nd edge; 1 word per cycle.
- ready=0, DEPTH=4 → exactly 4 issues, then read_bus_en=0; count=4. Raise ready for one cycle → one pop and one new issue.
- Jump to 16'h0200 while FIFO holds 3 entries plus one in flight → after the edge instr_valid=0; next issues are 0200 and 0201; no pre-jump word ever appears.
- fetch_pc=16'hFFFF, FETCH_FAULT_EN undefined → issues FFFF then 0000; instr_addr follows the same sequence.
- bus_grant toggled 1,0,1 → word from the first issue still captured; no issue in the grant=0 cycle; address sequence is contiguous with no gaps.
- FETCH_FAULT_EN, FETCH_HI=16'h0104, start at 0102 → 0102 and 0103 issued and drained; fetch_fault=1 at 0104 and stays set; jump to 0100 clears it.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// +----------------------------------------------------------------------+
// | fetch_unit_pkg : bus/address constants shared by the fetch front end  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

`ifndef WORD
`define WORD 15:0
`endif
`ifndef RAM_START
`define RAM_START 16'h0000
`endif
`ifndef RAM_END
`define RAM_END 16'h8000
`endif

package fetch_unit_pkg;

    localparam int BUS_WORD_SIZE = 16;
    localparam int FETCH_DEPTH   = 4;

    localparam logic [BUS_WORD_SIZE-1:0] RAM_START_ADDR = `RAM_START;
    localparam logic [BUS_WORD_SIZE-1:0] RAM_END_ADDR   = `RAM_END;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
// +----------------------------------------------------------------------+
// | fetch_fifo : DEPTH-entry prefetch FIFO with flush and async reset     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// +----------------------------------------------------------------------+
// | fetch_unit : sequential instruction fetch with prefetch FIFO/jumps.   |
// | Optional macro FETCH_FAULT_EN adds a sticky fetch-range fault. Rev 1.0|
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                   WORD_SIZE    = BUS_WORD_SIZE,
    parameter int                   DEPTH        = FETCH_DEPTH,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0
`ifdef FETCH_FAULT_EN
    ,
    parameter logic [WORD_SIZE-1:0] FETCH_LO     = WORD_SIZE'(RAM_START_ADDR),
    parameter logic [WORD_SIZE-1:0] FETCH_HI     = WORD_SIZE'(RAM_END_ADDR)
`endif
) (
    input  logic                 reset,
    input  logic                 read_clk,
    output logic [WORD_SIZE-1:0] read_bus,
    output logic                 read_bus_en,
    input  logic                 bus_grant,
    input  logic [WORD_SIZE-1:0] data_bus,
    input  logic                 jump_en,
    input  logic [WORD_SIZE-1:0] jump_addr,
    output logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] instr_addr,
    output logic                 instr_valid,
    input  logic                 instr_ready
`ifdef FETCH_FAULT_EN
    ,
    output logic                 fetch_fault
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WORD_SIZE-1:0]   fetch_pc;
    logic [WORD_SIZE-1:0]   issued_addr;
    logic                   inflight;
    logic [CW-1:0]          count;
    logic [2*WORD_SIZE-1:0] head;
    logic [CW:0]            occupancy;
    logic                   pop;
    logic                   space_ok;
    logic                   attempt;
    logic                   issue;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready;

    // The in-flight word already owns a slot, so it counts toward occupancy.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign space_ok  = (occupancy < (CW+1)'(DEPTH));
    assign attempt   = bus_grant & space_ok & ~jump_en;

`ifdef FETCH_FAULT_EN
    logic fault;
    logic in_range;

    assign in_range    = (fetch_pc >= FETCH_LO) && (fetch_pc < FETCH_HI);
    assign issue       = attempt & in_range & ~fault;
    assign fetch_fault = fault;

    always_ff @(posedge read_clk or posedge reset) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (jump_en) begin
            fault <= 1'b0;
        end else if (attempt & ~in_range) begin
            fault <= 1'b1;
        end
    end
`else
    assign issue = attempt;
`endif

    always_ff @(posedge read_clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_VECTOR;
            issued_addr <= '0;
            inflight    <= 1'b0;
            read_bus_en <= 1'b0;
            read_bus    <= '0;
        end else if (jump_en) begin
            fetch_pc    <= jump_addr;
            inflight    <= 1'b0;
            read_bus_en <= 1'b0;
            read_bus    <= '0;
        end else if (issue) begin
            read_bus    <= fetch_pc;
            read_bus_en <= 1'b1;
            issued_addr <= fetch_pc;
            inflight    <= 1'b1;
            fetch_pc    <= fetch_pc + 1'b1;
        end else begin
            read_bus_en <= 1'b0;
            read_bus    <= '0;
            inflight    <= 1'b0;
        end
    end

    // A jump voids both the returning word and any same-cycle pop.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*WORD_SIZE)
    ) u_fifo (
        .clk       (read_clk),
        .reset     (reset),
        .flush     (jump_en),
        .push      (inflight & ~jump_en),
        .pop       (pop & ~jump_en),
        .push_data ({data_bus, issued_addr}),
        .head      (head),
        .count     (count)
    );

    assign instr      = head[2*WORD_SIZE-1:WORD_SIZE];
    assign instr_addr = head[WORD_SIZE-1:0];

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// +----------------------------------------------------------------------+
// | tb_fetch_unit : randomized and directed bench with a queue-based model|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_unit;

    localparam int          W  = 16;
    localparam int          D  = 4;
    localparam logic [15:0] RV = 16'h0100;
`ifdef FETCH_FAULT_EN
    localparam logic [15:0] LO = 16'h0100;
    localparam logic [15:0] HI = 16'h0104;
`endif

    logic          reset = 1'b1;
    logic          read_clk = 1'b0;
    logic [W-1:0]  read_bus;
    logic          read_bus_en;
    logic          bus_grant = 1'b0;
    logic [W-1:0]  data_bus;
    logic          jump_en = 1'b0;
    logic [W-1:0]  jump_addr = '0;
    logic [W-1:0]  instr;
    logic [W-1:0]  instr_addr;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [W-1:0]  junk = '0;
`ifdef FETCH_FAULT_EN
    logic          fetch_fault;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Memory model: word at address a is a ^ A5A5; the bus floats otherwise.
    assign data_bus = read_bus_en ? (read_bus ^ 16'hA5A5) : junk;

    always #5 read_clk = ~read_clk;
    always @(negedge read_clk) junk <= W'($urandom);

    fetch_unit #(
        .WORD_SIZE    (W),
        .DEPTH        (D),
        .RESET_VECTOR (RV)
`ifdef FETCH_FAULT_EN
        ,
        .FETCH_LO     (LO),
        .FETCH_HI     (HI)
`endif
    ) dut (
        .reset       (reset),
        .read_clk    (read_clk),
        .read_bus    (read_bus),
        .read_bus_en (read_bus_en),
        .bus_grant   (bus_grant),
        .data_bus    (data_bus),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .instr       (instr),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
`ifdef FETCH_FAULT_EN
        ,
        .fetch_fault (fetch_fault)
`endif
    );

    // Reference model: a queue of buffered addresses plus the pending word.
    logic [15:0] m_q [$];
    logic [15:0] m_pc;
    logic [15:0] m_infl_addr;
    logic [15:0] m_bus;
    bit          m_infl;
    bit          m_en;
    bit          m_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_inrange(input logic [15:0] a);
`ifdef FETCH_FAULT_EN
        return (a >= LO) && (a < HI);
`else
        return (a == a);
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc = RV; m_infl = 0; m_infl_addr = '0;
        m_en = 0; m_bus = '0; m_fault = 0;
    endtask

    task automatic model_edge(input bit g, input bit r, input bit j, input logic [15:0] ja);
        bit p;
        bit att;
        bit iss;
        int occ;
        p   = (m_q.size() > 0) && r;
        occ = m_q.size() + int'(m_infl) - int'(p);
        if (j) begin
            m_q.delete();
            m_infl = 0; m_pc = ja; m_en = 0; m_bus = '0; m_fault = 0;
        end else begin
            att = g && (occ < D);
            iss = att && !m_fault && m_inrange(m_pc);
            if (att && !m_inrange(m_pc)) m_fault = 1;
            if (p) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_infl_addr);
            if (iss) begin
                m_en = 1; m_bus = m_pc; m_infl = 1; m_infl_addr = m_pc;
                m_pc = m_pc + 16'h1;
            end else begin
                m_en = 0; m_bus = '0; m_infl = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("read_bus_en", 32'(read_bus_en), 32'(m_en));
        check("read_bus", 32'(read_bus), 32'(m_bus));
        check("instr_valid", 32'(instr_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("instr_addr", 32'(instr_addr), 32'(m_q[0]));
            check("instr", 32'(instr), 32'(m_q[0] ^ 16'hA5A5));
        end
`ifdef FETCH_FAULT_EN
        check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
`endif
    endtask

    task automatic step(input bit g, input bit r, input bit j, input logic [15:0] ja);
        bus_grant = g; instr_ready = r; jump_en = j; jump_addr = ja;
        model_edge(g, r, j, ja);
        @(posedge read_clk);
        #1;
        compare_all();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_bus_en"}, 32'(read_bus_en), 32'd0);
        check({tag, "_bus"}, 32'(read_bus), 32'd0);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"}, 32'(instr), 32'd0);
        check({tag, "_iaddr"}, 32'(instr_addr), 32'd0);
`ifdef FETCH_FAULT_EN
        check({tag, "_fault"}, 32'(fetch_fault), 32'd0);
`endif
    endtask

    initial begin
        model_reset();
        #3;
        check_reset_state("reset");
        repeat (2) @(posedge read_clk);
        #1 reset = 1'b0;

        // Streaming from the reset vector.
        step(1, 1, 0, 16'h0);
        check("first_issue", 32'(read_bus), 32'h0100);
        step(1, 1, 0, 16'h0);
        check("first_instr", 32'(instr), 32'hA4A5);
        check("first_iaddr", 32'(instr_addr), 32'h0100);
        repeat (4) step(1, 1, 0, 16'h0);

        // Fill with the decoder stalled, then release one pop.
        step(1, 1, 1, RV);
        repeat (6) step(1, 0, 0, 16'h0);
        check("full_no_issue", 32'(read_bus_en), 32'd0);
        step(1, 1, 0, 16'h0);
        step(1, 0, 0, 16'h0);

        // Jump with three buffered entries plus one in flight.
        step(1, 1, 1, RV);
        repeat (4) step(1, 0, 0, 16'h0);
        step(1, 1, 1, 16'h0200);
        check("jump_flush", 32'(instr_valid), 32'd0);
        repeat (4) step(1, 1, 0, 16'h0);

        // Address wrap, and grant toggling.
        step(1, 1, 1, 16'hFFFE);
        repeat (4) step(1, 1, 0, 16'h0);
        step(1, 1, 1, RV);
        step(1, 1, 0, 16'h0);
        step(0, 1, 0, 16'h0);
        step(1, 1, 0, 16'h0);
        step(1, 1, 0, 16'h0);

`ifdef FETCH_FAULT_EN
        step(1, 1, 1, 16'h0102);
        repeat (6) step(1, 1, 0, 16'h0);
        check("fault_set", 32'(fetch_fault), 32'd1);
        step(1, 1, 1, 16'h0100);
        check("fault_clear", 32'(fetch_fault), 32'd0);
`endif

        // Reset in the middle of traffic.
        step(1, 1, 1, RV);
        repeat (3) step(1, 0, 0, 16'h0);
        reset = 1'b1;
        #1;
        check_reset_state("midreset");
        model_reset();
        @(posedge read_clk);
        #1 reset = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            logic [15:0] ja;
            case ($urandom_range(0, 4))
                0: ja = RV;
                1: ja = 16'hFFFE;
                2: ja = 16'h0102;
                3: ja = 16'h0200;
                default: ja = 16'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0, ja);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
